// File: rtl/mul_seq.sv
// mul_seq: iterative shift-add multiplier for MUL / UMULL / SMULL.
// One partial-product step per cycle; fixed latency independent of data.
// SMULL runs on operand magnitudes and fixes the sign in a single extra cycle.
module mul_seq #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       MulOp,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic             flush,
    output logic             busy,
    output logic             Stall,
    output logic             done,
    output logic [WIDTH-1:0] ResultLo,
    output logic [WIDTH-1:0] ResultHi
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_SMULL = 2'b10;
    localparam logic [1:0] OP_RSV   = 2'b11;

    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(WIDTH - 1);
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);

    // Unsigned magnitude of a two's-complement word; -2^(W-1) maps to 2^(W-1).
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] r;
        if (x[WIDTH-1]) begin
            r = ~x + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            r = x;
        end
        return r;
    endfunction

    // Two's-complement negation over the full double-width product.
    function automatic logic [2*WIDTH-1:0] neg2w(input logic [2*WIDTH-1:0] x);
        return ~x + {{(2*WIDTH-1){1'b0}}, 1'b1};
    endfunction

    logic [1:0]       state_q,  state_d;
    logic [CNTW-1:0]  cnt_q,    cnt_d;
    logic [1:0]       op_q,     op_d;
    logic             neg_q,    neg_d;
    logic [WIDTH-1:0] mcand_q,  mcand_d;
    logic [WIDTH-1:0] hi_q,     hi_d;
    logic [WIDTH-1:0] lo_q,     lo_d;
    logic [WIDTH-1:0] res_lo_q, res_lo_d;
    logic [WIDTH-1:0] res_hi_q, res_hi_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;

    logic             accept_s;
    logic [WIDTH:0]   sum_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] fixed_s;

    // Datapath helpers: conditional add of the multiplicand and final sign fix.
    always_comb begin
        if (lo_q[0]) begin
            sum_s = {1'b0, hi_q} + {1'b0, mcand_q};
        end else begin
            sum_s = {1'b0, hi_q};
        end
        prod_s = {hi_q, lo_q};
        if (neg_q) begin
            fixed_s = neg2w(prod_s);
        end else begin
            fixed_s = prod_s;
        end
    end

    // A request is taken only when idle or finishing, and never for the reserved op.
    always_comb begin
        if (((state_q == S_IDLE) || (state_q == S_DONE)) && start && (MulOp != OP_RSV)) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
    end

    // Next-state and datapath update for the sequencer.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_d    = neg_q;
        mcand_d  = mcand_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        res_lo_d = res_lo_q;
        res_hi_d = res_hi_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept_s) begin
                    state_d = S_CALC;
                    op_d    = MulOp;
                    hi_d    = {WIDTH{1'b0}};
                    cnt_d   = {CNTW{1'b0}};
                    if (MulOp == OP_SMULL) begin
                        mcand_d = mag(SrcA);
                        lo_d    = mag(SrcB);
                        neg_d   = SrcA[WIDTH-1] ^ SrcB[WIDTH-1];
                    end else begin
                        mcand_d = SrcA;
                        lo_d    = SrcB;
                        neg_d   = 1'b0;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    // Shift {carry, hi, lo} right by one; lo[0] has been consumed.
                    hi_d  = sum_s[WIDTH:1];
                    lo_d  = {sum_s[0], lo_q[WIDTH-1:1]};
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_FIX;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_FIX: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    // Result registers load as DONE is entered so they line up with done.
                    hi_d     = fixed_s[2*WIDTH-1:WIDTH];
                    lo_d     = fixed_s[WIDTH-1:0];
                    res_lo_d = fixed_s[WIDTH-1:0];
                    if (op_q == OP_MUL) begin
                        res_hi_d = {WIDTH{1'b0}};
                    end else begin
                        res_hi_d = fixed_s[2*WIDTH-1:WIDTH];
                    end
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Status flags are decoded from the next state so they track the state register exactly.
    always_comb begin
        if ((state_d == S_CALC) || (state_d == S_FIX)) begin
            busy_d = 1'b1;
        end else begin
            busy_d = 1'b0;
        end
        if (state_d == S_DONE) begin
            done_d = 1'b1;
        end else begin
            done_d = 1'b0;
        end
    end

    // State, accumulators and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= {CNTW{1'b0}};
            op_q     <= 2'b00;
            neg_q    <= 1'b0;
            mcand_q  <= {WIDTH{1'b0}};
            hi_q     <= {WIDTH{1'b0}};
            lo_q     <= {WIDTH{1'b0}};
            res_lo_q <= {WIDTH{1'b0}};
            res_hi_q <= {WIDTH{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            mcand_q  <= mcand_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            res_lo_q <= res_lo_d;
            res_hi_q <= res_hi_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign Stall    = busy_q | accept_s;
    assign ResultLo = res_lo_q;
    assign ResultHi = res_hi_q;

endmodule

// File: tb/tb_mul_seq.sv
// Directed bench for mul_seq: hand-computed products, timing, flush, reset, reserved op.
module tb_mul_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  MulOp;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        flush;
    logic        busy;
    logic        Stall;
    logic        done;
    logic [31:0] ResultLo;
    logic [31:0] ResultHi;

    int total = 0;
    int bad   = 0;
    int pulses;

    mul_seq #(.WIDTH(32), .CNTW(5)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .MulOp    (MulOp),
        .SrcA     (SrcA),
        .SrcB     (SrcB),
        .flush    (flush),
        .busy     (busy),
        .Stall    (Stall),
        .done     (done),
        .ResultLo (ResultLo),
        .ResultHi (ResultHi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive a request now (between edges), check Stall, then drop start after the accepting edge.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        MulOp = op;
        SrcA  = a;
        SrcB  = b;
        #1;
        chk("stall_on_accept", {71'd0, Stall}, 72'd1);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called one half-cycle after the accepting edge; follows 33 busy cycles then the done cycle.
    task automatic track(input string tag, input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                         input logic [31:0] prev_lo, input logic [31:0] prev_hi, input bit mid_pulse);
        for (int k = 0; k < 33; k++) begin
            if (k != 0) @(negedge clk);
            chk({tag, "_busy"}, {6'd0, busy, done, prev_hi, prev_lo}, {6'd0, 1'b1, 1'b0, prev_hi, prev_lo});
            if (mid_pulse && (k == 10)) begin
                start = 1'b1;
                MulOp = 2'b00;
                SrcA  = 32'hFFFF_FFFF;
                SrcB  = 32'h0000_0002;
                #1;
                chk({tag, "_stall_busy"}, {71'd0, Stall}, 72'd1);
            end
            if (k == 11) start = 1'b0;
        end
        @(negedge clk);
        chk({tag, "_done"}, {6'd0, busy, done, ResultHi, ResultLo}, {6'd0, 1'b0, 1'b1, exp_hi, exp_lo});
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        MulOp = 2'b00;
        SrcA  = 32'd0;
        SrcB  = 32'd0;
        flush = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_state", {5'd0, busy, done, Stall, ResultHi, ResultLo}, 72'd0);
        reset = 1'b1;
        @(negedge clk);

        // MUL 7*6
        issue(2'b00, 32'd7, 32'd6);
        track("mul_7x6", 32'h0000_002A, 32'h0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        chk("mul_done_single", {71'd0, done}, 72'd0);

        // UMULL all-ones squared
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        track("umull_ff", 32'h0000_0001, 32'hFFFF_FFFE, 32'h0000_002A, 32'h0, 1'b0);
        @(negedge clk);
        chk("umull_done_single", {71'd0, done}, 72'd0);

        // SMULL -3*5
        issue(2'b10, 32'hFFFF_FFFD, 32'd5);
        track("smull_m3x5", 32'hFFFF_FFF1, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
        @(negedge clk);

        // SMULL most-negative squared
        issue(2'b10, 32'h8000_0000, 32'h8000_0000);
        track("smull_min_sq", 32'h0000_0000, 32'h4000_0000, 32'hFFFF_FFF1, 32'hFFFF_FFFF, 1'b0);
        @(negedge clk);

        // SMULL most-negative * 1
        issue(2'b10, 32'h8000_0000, 32'd1);
        track("smull_min_x1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h4000_0000, 1'b0);
        @(negedge clk);

        // UMULL with operand changes and a start pulse while busy
        issue(2'b01, 32'h1234_5678, 32'h0000_0010);
        SrcA = 32'hDEAD_BEEF;
        SrcB = 32'h0BAD_F00D;
        track("umull_ignore", 32'h2345_6780, 32'h0000_0001, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        @(negedge clk);

        // Back-to-back: new MUL issued in the DONE cycle
        issue(2'b01, 32'h0001_0000, 32'h0001_0000);
        track("umull_2p32", 32'h0000_0000, 32'h0000_0001, 32'h2345_6780, 32'h0000_0001, 1'b0);
        issue(2'b00, 32'd3, 32'd3);
        track("b2b_mul_3x3", 32'h0000_0009, 32'h0, 32'h0000_0000, 32'h0000_0001, 1'b0);
        @(negedge clk);

        // Flush mid-calculation
        issue(2'b01, 32'd5, 32'd5);
        for (int k = 1; k <= 15; k++) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_idle", {6'd0, busy, done, ResultHi, ResultLo}, {6'd0, 1'b0, 1'b0, 32'h0, 32'h9});
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done || busy) pulses++;
        end
        chk("flush_no_done", pulses, 72'd0);

        // Asynchronous reset mid-operation
        issue(2'b01, 32'd2, 32'd2);
        for (int k = 1; k <= 20; k++) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset_mid_op", {5'd0, busy, done, Stall, ResultHi, ResultLo}, 72'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        issue(2'b00, 32'd7, 32'd6);
        track("post_reset_mul", 32'h0000_002A, 32'h0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);

        // Reserved op is ignored
        start = 1'b1;
        MulOp = 2'b11;
        SrcA  = 32'd4;
        SrcB  = 32'd4;
        #1;
        chk("rsv_stall", {71'd0, Stall}, 72'd0);
        @(negedge clk);
        start = 1'b0;
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            if (done || busy) pulses++;
            @(negedge clk);
        end
        chk("rsv_no_activity", pulses, 72'd0);
        chk("rsv_results_held", {8'd0, ResultHi, ResultLo}, {8'd0, 32'h0, 32'h2A});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
